// File: rtl/n1_stack_pkg.sv
// Shared types and constants for the N1 stack memory path.
package n1_stack_pkg;

    localparam int unsigned CELL_W = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } ram_state_e;

endpackage

// File: rtl/n1_stack_ram_array.sv
// Stack RAM cell array: one write and one registered read per clock, contents never reset.
module n1_stack_ram_array
    import n1_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [CELL_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [CELL_W-1:0] rdata_o
);

    logic [CELL_W-1:0] r_mem [DEPTH];

    // Read returns the old cell value on a same-edge write; the caller bypasses.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        rdata_o <= r_mem[raddr_i];
    end

endmodule

// File: rtl/n1_stack_ram_tgt.sv
// Pipelined Wishbone target for the lower stack memory: wait states, range error,
// write-first bypass and a held read-data register.
module n1_stack_ram_tgt
    import n1_stack_pkg::*;
#(
    parameter int unsigned SP_WIDTH    = 12,
    parameter int unsigned MEM_DEPTH   = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                sarb2ram_cyc_i,
    input  logic                sarb2ram_stb_i,
    input  logic                sarb2ram_we_i,
    input  logic [SP_WIDTH-1:0] sarb2ram_adr_i,
    input  logic [CELL_W-1:0]   sarb2ram_dat_i,
    output logic                ram2sarb_ack_o,
    output logic                ram2sarb_err_o,
    output logic                ram2sarb_rty_o,
    output logic                ram2sarb_stall_o,
    output logic [CELL_W-1:0]   ram2sarb_dat_o,
    output logic [1:0]          prb_ram_state_o
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [SP_WIDTH:0] DEPTH_LIM = (SP_WIDTH + 1)'(MEM_DEPTH);

    ram_state_e          r_state, w_state_nxt;
    logic [3:0]          r_wcnt, w_wcnt_nxt;
    logic [SP_WIDTH-1:0] r_adr;
    logic                r_we;
    logic [CELL_W-1:0]   r_wdat;
    logic [CELL_W-1:0]   r_dat;
    logic                r_byp;
    logic [CELL_W-1:0]   r_byp_dat;

    logic                w_stall;
    logic                w_accept;
    logic                w_oor;
    logic                w_resp;
    logic                w_ack;
    logic                w_err;
    logic                w_ram_we;
    logic                w_rd_ack;
    logic [AW-1:0]       w_raddr;
    logic [CELL_W-1:0]   w_ram_rdata;
    logic [CELL_W-1:0]   w_rd_data;

    assign w_stall  = (r_state == StWait);
    assign w_accept = sarb2ram_cyc_i & sarb2ram_stb_i & ~w_stall;
    assign w_oor    = {1'b0, r_adr} >= DEPTH_LIM;

    // A dropped cycle or a reset pending at the edge kills the response and the commit.
    assign w_resp   = (r_state == StResp) & sarb2ram_cyc_i & sync_rst_i;
    assign w_ack    = w_resp & ~w_oor;
    assign w_err    = w_resp & w_oor;
    assign w_ram_we = w_ack & r_we;
    assign w_rd_ack = w_ack & ~r_we;

    // The read must be issued one cycle before RESP: from the latch while waiting,
    // otherwise straight from the bus in the accept cycle.
    assign w_raddr   = w_stall ? r_adr[AW-1:0] : sarb2ram_adr_i[AW-1:0];
    assign w_rd_data = r_byp ? r_byp_dat : w_ram_rdata;

    n1_stack_ram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_ram_we),
        .waddr_i (r_adr[AW-1:0]),
        .wdata_i (r_wdat),
        .raddr_i (w_raddr),
        .rdata_o (w_ram_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        unique case (r_state)
            StIdle, StResp: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = StWait;
                        w_wcnt_nxt  = WAIT_LOAD;
                    end else begin
                        w_state_nxt = StResp;
                    end
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StWait: begin
                if (!sarb2ram_cyc_i) begin
                    w_state_nxt = StIdle;
                end else if (r_wcnt == 4'd0) begin
                    w_state_nxt = StResp;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_state <= StIdle;
            r_wcnt  <= 4'd0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_rd_ack) begin
                r_dat <= w_rd_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_adr  <= sarb2ram_adr_i;
            r_we   <= sarb2ram_we_i;
            r_wdat <= sarb2ram_dat_i;
        end
        r_byp     <= w_ram_we & (w_raddr == r_adr[AW-1:0]);
        r_byp_dat <= r_wdat;
    end

    assign ram2sarb_ack_o   = w_ack;
    assign ram2sarb_err_o   = w_err;
    assign ram2sarb_rty_o   = 1'b0;
    assign ram2sarb_stall_o = w_stall;
    assign ram2sarb_dat_o   = w_rd_ack ? w_rd_data : r_dat;
    assign prb_ram_state_o  = r_state;

endmodule

// File: tb/tb_n1_stack_ram_tgt.sv
// Bench for n1_stack_ram_tgt: three parameterisations against a transaction-level model.
module tb_n1_stack_ram_tgt;

    localparam int NDUT = 3;

    function automatic int unsigned ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic int unsigned depth_of(input int k);
        return (k == 0) ? 2048 : 4096;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [NDUT];
    logic        cyc   [NDUT];
    logic        stb   [NDUT];
    logic        we    [NDUT];
    logic [11:0] adr   [NDUT];
    logic [15:0] wd    [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];
    logic        rty   [NDUT];
    logic        stall [NDUT];
    logic [15:0] rdo   [NDUT];
    logic [1:0]  prb   [NDUT];

    n1_stack_ram_tgt #(.SP_WIDTH(12), .MEM_DEPTH(2048), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .sync_rst_i(rst_n[0]), .sarb2ram_cyc_i(cyc[0]), .sarb2ram_stb_i(stb[0]),
        .sarb2ram_we_i(we[0]), .sarb2ram_adr_i(adr[0]), .sarb2ram_dat_i(wd[0]),
        .ram2sarb_ack_o(ack[0]), .ram2sarb_err_o(err[0]), .ram2sarb_rty_o(rty[0]),
        .ram2sarb_stall_o(stall[0]), .ram2sarb_dat_o(rdo[0]), .prb_ram_state_o(prb[0])
    );

    n1_stack_ram_tgt #(.SP_WIDTH(12), .MEM_DEPTH(4096), .WAIT_STATES(3)) u_dut1 (
        .clk_i(clk), .sync_rst_i(rst_n[1]), .sarb2ram_cyc_i(cyc[1]), .sarb2ram_stb_i(stb[1]),
        .sarb2ram_we_i(we[1]), .sarb2ram_adr_i(adr[1]), .sarb2ram_dat_i(wd[1]),
        .ram2sarb_ack_o(ack[1]), .ram2sarb_err_o(err[1]), .ram2sarb_rty_o(rty[1]),
        .ram2sarb_stall_o(stall[1]), .ram2sarb_dat_o(rdo[1]), .prb_ram_state_o(prb[1])
    );

    n1_stack_ram_tgt #(.SP_WIDTH(12), .MEM_DEPTH(4096), .WAIT_STATES(2)) u_dut2 (
        .clk_i(clk), .sync_rst_i(rst_n[2]), .sarb2ram_cyc_i(cyc[2]), .sarb2ram_stb_i(stb[2]),
        .sarb2ram_we_i(we[2]), .sarb2ram_adr_i(adr[2]), .sarb2ram_dat_i(wd[2]),
        .ram2sarb_ack_o(ack[2]), .ram2sarb_err_o(err[2]), .ram2sarb_rty_o(rty[2]),
        .ram2sarb_stall_o(stall[2]), .ram2sarb_dat_o(rdo[2]), .prb_ram_state_o(prb[2])
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: a pending access responds after WAIT_STATES stall cycles; memory and the
    // held read value change only when a response is actually delivered.
    logic [15:0] mmem   [NDUT][4096];
    bit          mknown [NDUT][4096];
    bit          live   [NDUT];
    bit          pend   [NDUT];
    int          rem    [NDUT];
    logic [11:0] padr   [NDUT];
    bit          pwe    [NDUT];
    logic [15:0] pdat   [NDUT];
    logic [15:0] hold   [NDUT];
    bit          hknown [NDUT];

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            automatic bit oor = (int'(padr[k]) >= int'(depth_of(k)));
            automatic bit rsp = pend[k] && (rem[k] == 0);
            automatic bit stl = pend[k] && (rem[k] > 0);
            automatic bit acc = cyc[k] && stb[k] && !stl;
            if (!rst_n[k]) begin
                pend[k]   = 1'b0;
                hold[k]   = 16'h0000;
                hknown[k] = 1'b1;
                live[k]   = 1'b1;
            end else if (live[k]) begin
                if (pend[k] && !cyc[k]) begin
                    pend[k] = 1'b0;
                end else if (rsp) begin
                    if (!oor && pwe[k]) begin
                        mmem[k][padr[k]]   = pdat[k];
                        mknown[k][padr[k]] = 1'b1;
                    end else if (!oor) begin
                        hold[k]   = mmem[k][padr[k]];
                        hknown[k] = mknown[k][padr[k]];
                    end
                    pend[k] = 1'b0;
                end else if (pend[k]) begin
                    rem[k] = rem[k] - 1;
                end
                if (acc) begin
                    pend[k] = 1'b1;
                    rem[k]  = int'(ws_of(k));
                    padr[k] = adr[k];
                    pwe[k]  = we[k];
                    pdat[k] = wd[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (live[k]) begin
                automatic bit oor  = (int'(padr[k]) >= int'(depth_of(k)));
                automatic bit rsp  = pend[k] && (rem[k] == 0) && cyc[k] && rst_n[k];
                automatic bit rd   = rsp && !oor && !pwe[k];
                automatic logic [15:0] edat = rd ? mmem[k][padr[k]] : hold[k];
                automatic bit eknown = rd ? mknown[k][padr[k]] : hknown[k];
                automatic logic [1:0] est = !pend[k] ? 2'd0 : ((rem[k] > 0) ? 2'd1 : 2'd2);
                check("ack", k, 32'(ack[k]), 32'(rsp && !oor));
                check("err", k, 32'(err[k]), 32'(rsp && oor));
                check("stall", k, 32'(stall[k]), 32'(pend[k] && (rem[k] > 0)));
                check("rty", k, 32'(rty[k]), 32'd0);
                check("state", k, 32'(prb[k]), 32'(est));
                if (eknown) check("dat", k, 32'(rdo[k]), 32'(edat));
            end
        end
    end

    task automatic xfer(input int k, input logic w, input logic [11:0] a, input logic [15:0] d,
                        output int lat, output logic gack, output logic gerr,
                        output logic [15:0] rd);
        int n;
        @(posedge clk); #1;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wd[k] = d;
        n = 0;
        @(negedge clk);
        while (stall[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        stb[k] = 1'b0;
        lat = 0; gack = 1'b0; gerr = 1'b0; rd = '0;
        while (!(gack || gerr) && lat < 40) begin
            @(negedge clk);
            lat++;
            gack = ack[k]; gerr = err[k]; rd = rdo[k];
            @(posedge clk); #1;
        end
        cyc[k] = 1'b0;
        if (!(gack || gerr)) check("xfer_timeout", k, 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        ga, ge, seen;
        logic [15:0] rd;
        logic [11:0] av, sv;
        for (int k = 0; k < NDUT; k++) begin
            rst_n[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
            we[k] = 1'b0; adr[k] = '0; wd[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;
        @(negedge clk);
        check("rst_ack", 0, 32'(ack[0]), 32'd0);
        check("rst_err", 0, 32'(err[0]), 32'd0);
        check("rst_stall", 0, 32'(stall[0]), 32'd0);
        check("rst_dat", 0, 32'(rdo[0]), 32'h0000);
        check("rst_prb", 0, 32'(prb[0]), 32'd0);

        // Basic write then read, zero wait states.
        xfer(0, 1'b1, 12'h010, 16'hA5A5, lat, ga, ge, rd);
        check("t1_wr_ack", 0, 32'(ga), 32'd1);
        check("t1_wr_lat", 0, 32'(lat), 32'd1);
        xfer(0, 1'b0, 12'h010, 16'h0000, lat, ga, ge, rd);
        check("t1_rd_lat", 0, 32'(lat), 32'd1);
        check("t1_rd_dat", 0, 32'(rd), 32'hA5A5);

        // Three wait states with the request held through the stalls.
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h0FF; wd[1] = 16'h1234;
        @(posedge clk); #1;
        we[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            av[i] = ack[1];
            sv[i] = stall[1];
            if (i == 7 || i == 11) check("t2_rd_dat", 1, 32'(rdo[1]), 32'h1234);
        end
        check("t2_ack_pattern", 1, 32'(av), 32'h888);
        check("t2_stall_pattern", 1, 32'(sv), 32'h777);
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 12'(i), 16'(i + 1), lat, ga, ge, rd);
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 12'h000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) adr[0] = 12'(i + 1);
            else stb[0] = 1'b0;
            @(negedge clk);
            check("t3_ack", 0, 32'(ack[0]), 32'd1);
            check("t3_dat", 0, 32'(rdo[0]), 32'(i + 1));
            check("t3_stall", 0, 32'(stall[0]), 32'd0);
        end
        @(posedge clk); #1;
        cyc[0] = 1'b0;

        // Out-of-range accesses on the 2048-deep instance.
        xfer(0, 1'b1, 12'h800, 16'hFFFF, lat, ga, ge, rd);
        check("t4_wr_err", 0, 32'({ga, ge}), 32'b01);
        check("t4_wr_lat", 0, 32'(lat), 32'd1);
        xfer(0, 1'b0, 12'h800, 16'h0000, lat, ga, ge, rd);
        check("t4_rd_err", 0, 32'({ga, ge}), 32'b01);
        check("t4_rd_hold", 0, 32'(rd), 32'h0004);

        // Read directly behind a write to the same cell.
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 12'h020; wd[0] = 16'hBEEF;
        @(posedge clk); #1;
        we[0] = 1'b0;
        @(negedge clk);
        check("t5_wr_ack", 0, 32'(ack[0]), 32'd1);
        @(posedge clk); #1;
        stb[0] = 1'b0;
        @(negedge clk);
        check("t5_rd_ack", 0, 32'(ack[0]), 32'd1);
        check("t5_bypass", 0, 32'(rdo[0]), 32'hBEEF);
        @(posedge clk); #1;
        cyc[0] = 1'b0;

        // Abort by dropped cycle, then by reset; the pending write must not land.
        xfer(2, 1'b1, 12'h030, 16'h1111, lat, ga, ge, rd);
        @(posedge clk); #1;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 12'h030; wd[2] = 16'hDEAD;
        @(posedge clk); #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | ack[2] | err[2];
        end
        check("t6_abort_resp", 2, 32'(seen), 32'd0);
        xfer(2, 1'b0, 12'h030, 16'h0000, lat, ga, ge, rd);
        check("t6_abort_old", 2, 32'(rd), 32'h1111);
        @(posedge clk); #1;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 12'h030; wd[2] = 16'hDEAD;
        @(posedge clk); #1;
        stb[2] = 1'b0; rst_n[2] = 1'b0;
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | ack[2] | err[2];
        end
        check("t6_reset_resp", 2, 32'(seen), 32'd0);
        @(posedge clk); #1;
        cyc[2] = 1'b0;
        xfer(2, 1'b0, 12'h030, 16'h0000, lat, ga, ge, rd);
        check("t6_reset_old", 2, 32'(rd), 32'h1111);

        // Random traffic, including protocol-level aborts and resets.
        for (int k = 0; k < NDUT; k++) begin
            repeat (600) begin
                int unsigned r;
                @(posedge clk); #1;
                rst_n[k] = ($urandom_range(0, 99) != 0);
                cyc[k]   = ($urandom_range(0, 99) < 85);
                stb[k]   = ($urandom_range(0, 99) < 60);
                we[k]    = 1'($urandom_range(0, 1));
                wd[k]    = 16'($urandom);
                r = $urandom_range(0, 9);
                if (r < 7) adr[k] = 12'($urandom_range(0, 15));
                else if (r == 7) adr[k] = 12'(depth_of(k) - 1);
                else if (r == 8) adr[k] = 12'h800;
                else adr[k] = 12'hFFF;
            end
            @(posedge clk); #1;
            rst_n[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0;
            repeat (2) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
